ex_csr_unit: RTL and testbench
==============================

# ex_csr_unit

Parametrised execute-stage CSR unit: decodes and executes the six Zicsr read-modify-write operations against its own machine-mode CSR file and returns the old CSR value for register writeback one cycle later. It adds cycle and instret counters, trap/mret state updates and illegal-access detection. It sits in the EX stage beside the ALU, fed by the decoder, and drives the writeback mux and the trap controller.

## Interface
- XLEN, 64, data width of CSRs, rs1 operand and writeback data; 32 or 64.
- HAS_COUNTERS, 1, 1 implements mcycle/minstret/cycle/instret; 0 makes those addresses illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- valid_i  in  1  CSR instruction present this cycle.
- flush_i  in  1  kill the current request; no CSR write, no writeback.
- csr_op_i  in  3  001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci; other codes are illegal.
- csr_addr_i  in  12  CSR address.
- rs1_idx_i  in  5  rs1 index; zero-extended to XLEN as zimm for the immediate forms.
- data_rs1_i  in  XLEN  rs1 value.
- rd_idx_i  in  5  destination register.
- retire_i  in  1  one instruction retired this cycle.
- trap_i  in  1  take a trap this cycle.
- trap_pc_i  in  XLEN  PC of the trapping instruction.
- trap_cause_i  in  XLEN  cause code.
- mret_i  in  1  execute mret.
- wb_valid_o  out  1  writeback valid; registered.
- wb_rd_idx_o  out  5  writeback index; registered.
- wb_data_o  out  XLEN  old CSR value; registered.
- illegal_o  out  1  one-cycle pulse: illegal CSR access; registered.
- mtvec_o, mepc_o  out  XLEN  current register values, for the trap controller.
- mie_o  out  1  mstatus.MIE.

## Operation
- CSR map: mstatus 0x300 (only MIE bit 3 and MPIE bit 7 are writable; all other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, cycle 0xC00, instret 0xC02 (cycle/instret are read-only aliases).
- Forced bits: mtvec[1:0] and mepc[1:0] always read and store 0.
- New value for each operation: rw gives src. rs gives old|src. rc gives old&~src. src is data_rs1_i for register forms and zimm for immediate forms.
- Write suppression: rs, rc, rsi and rci with rs1_idx_i==0 perform no write and cannot raise a write-illegal. rw and rwi always write. The read always happens.
- Illegal: unmapped address, reserved csr_op_i, or a write to an address with [11:10]==2'b11. An illegal access causes no CSR change and wb_valid_o=0, and illegal_o pulses.
- Writeback: wb_valid_o=1 only for a legal accepted request with rd_idx_i!=0.
- Trap (trap_i): mepc<=trap_pc_i with low bits cleared, mcause<=trap_cause_i, MPIE<=MIE, MIE<=0.
- mret (mret_i): MIE<=MPIE, MPIE<=1.
- Counters: mcycle increments every cycle. minstret increments when retire_i=1. Both wrap modulo 2^XLEN.

## Timing
- A request is accepted when valid_i=1 and flush_i=0 in cycle N. The CSR write takes effect at the end of cycle N. wb_*/illegal_o are valid in cycle N+1 for exactly one cycle.
- Back-to-back requests to the same CSR: the N+1 request reads the value written in cycle N.
- Priority within a cycle: trap_i > mret_i > CSR instruction. When trap_i or mret_i is high, a concurrent request is dropped: no write, no writeback, no illegal pulse. trap_i and mret_i together: the trap wins.
- Software write vs increment in the same cycle: the written value wins and that cycle's increment is lost.
- Reset (asynchronous, any time, including mid-request): all CSRs 0, wb_valid_o=0, wb_rd_idx_o=0, wb_data_o=0, illegal_o=0. Any in-flight writeback is dropped.

## Test plan
- Reset, then csrrw x5, mscratch with rs1=0x1234: next cycle wb_valid_o=1, rd=5, data=0. A following csrrs x6, mscratch with rs1 index 0 returns 0x1234 and leaves mscratch unchanged.
- csrrwi mtvec, zimm=0x1F: mtvec_o=0x1C. csrrci mstatus, zimm=8 clears MIE.
- Write to 0xC00 or to 0x7C0 (unmapped): illegal_o=1, wb_valid_o=0, no CSR change. csrrs cycle with rs1 index 0 is legal and returns mcycle.
- trap_i with trap_pc_i=0x80000102, cause=0xB while MIE=1: mepc=0x80000100, mcause=0xB, MIE=0, MPIE=1. Then mret_i: MIE=1. A concurrent csrrw in either cycle is dropped.
- mcycle written to all-ones: the written value holds for the write cycle, then the counter wraps to 0 and continues. minstret counts exactly the retire_i pulses.
- Assert rst_n low in the cycle after an accepted request: wb_valid_o is forced to 0 immediately and all CSRs read 0 after release.

Source files
------------

// File: rtl/ex_csr_unit.sv
// Execute-stage machine-mode CSR unit: Zicsr read-modify-write, counters,
// trap/mret status updates and illegal-access detection with registered writeback.
module ex_csr_unit #(
    parameter int XLEN         = 64,
    parameter bit HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [XLEN-1:0] data_rs1_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            retire_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic            mret_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_idx_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;

    localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mcycle, minstret;

    logic [XLEN-1:0] rdata, src, new_val, zimm;
    logic            mapped, op_legal, writes, illegal, accept, do_write;

    assign zimm     = {{(XLEN-5){1'b0}}, rs1_idx_i};
    assign src      = csr_op_i[2] ? zimm : data_rs1_i;
    assign op_legal = (csr_op_i[1:0] != 2'b00);
    // Set/clear forms with rs1 index 0 are pure reads; only rw/rwi always write.
    assign writes   = (csr_op_i[1:0] == 2'b01) || (rs1_idx_i != 5'd0);
    assign illegal  = !op_legal || !mapped || (writes && csr_addr_i[11:10] == 2'b11);
    assign accept   = valid_i && !flush_i && !trap_i && !mret_i;
    assign do_write = accept && !illegal && writes;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rdata  = '0;
        mapped = 1'b0;
        unique case (csr_addr_i)
            ADDR_MSTATUS: begin
                mapped   = 1'b1;
                rdata[3] = mie;
                rdata[7] = mpie;
            end
            ADDR_MTVEC:    begin mapped = 1'b1; rdata = mtvec;    end
            ADDR_MSCRATCH: begin mapped = 1'b1; rdata = mscratch; end
            ADDR_MEPC:     begin mapped = 1'b1; rdata = mepc;     end
            ADDR_MCAUSE:   begin mapped = 1'b1; rdata = mcause;   end
            ADDR_MCYCLE, ADDR_CYCLE: begin
                mapped = HAS_COUNTERS;
                rdata  = mcycle;
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                mapped = HAS_COUNTERS;
                rdata  = minstret;
            end
            default: ;
        endcase
    end

    always_comb begin
        new_val = rdata;
        unique case (csr_op_i[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = rdata | src;
            2'b11:   new_val = rdata & ~src;
            default: new_val = rdata;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
        end else if (trap_i) begin
            mpie <= mie;
            mie  <= 1'b0;
        end else if (mret_i) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (do_write && csr_addr_i == ADDR_MSTATUS) begin
            mie  <= new_val[3];
            mpie <= new_val[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (trap_i) begin
            mepc   <= trap_pc_i & LOW2_MASK;
            mcause <= trap_cause_i;
        end else if (do_write) begin
            if (csr_addr_i == ADDR_MTVEC)    mtvec    <= new_val & LOW2_MASK;
            if (csr_addr_i == ADDR_MSCRATCH) mscratch <= new_val;
            if (csr_addr_i == ADDR_MEPC)     mepc     <= new_val & LOW2_MASK;
            if (csr_addr_i == ADDR_MCAUSE)   mcause   <= new_val;
        end
    end

    // A software write replaces the increment of that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else if (!HAS_COUNTERS) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (do_write && csr_addr_i == ADDR_MCYCLE) mcycle <= new_val;
            else                                       mcycle <= mcycle + XLEN'(1);
            if (do_write && csr_addr_i == ADDR_MINSTRET) minstret <= new_val;
            else if (retire_i)                           minstret <= minstret + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o  <= 1'b0;
            wb_rd_idx_o <= '0;
            wb_data_o   <= '0;
            illegal_o   <= 1'b0;
        end else begin
            wb_valid_o  <= accept && !illegal && (rd_idx_i != 5'd0);
            wb_rd_idx_o <= rd_idx_i;
            wb_data_o   <= rdata;
            illegal_o   <= accept && illegal;
        end
    end

    assign mtvec_o = mtvec;
    assign mepc_o  = mepc;
    assign mie_o   = mie;

endmodule

// File: tb/tb_ex_csr_unit.sv
// Scoreboard bench for ex_csr_unit: driver predicts from an address-keyed CSR
// model, a negedge monitor pops and compares every writeback/illegal pulse.
module tb_ex_csr_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_i = 1'b0, flush_i = 1'b0, retire_i = 1'b0, trap_i = 1'b0, mret_i = 1'b0;
    logic [2:0]      csr_op_i = '0;
    logic [11:0]     csr_addr_i = '0;
    logic [4:0]      rs1_idx_i = '0, rd_idx_i = '0;
    logic [XLEN-1:0] data_rs1_i = '0, trap_pc_i = '0, trap_cause_i = '0;
    logic            wb_valid_o, illegal_o, mie_o;
    logic [4:0]      wb_rd_idx_o;
    logic [XLEN-1:0] wb_data_o, mtvec_o, mepc_o;

    ex_csr_unit #(.XLEN(XLEN), .HAS_COUNTERS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
        .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .rs1_idx_i(rs1_idx_i),
        .data_rs1_i(data_rs1_i), .rd_idx_i(rd_idx_i), .retire_i(retire_i),
        .trap_i(trap_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
        .mret_i(mret_i), .wb_valid_o(wb_valid_o), .wb_rd_idx_o(wb_rd_idx_o),
        .wb_data_o(wb_data_o), .illegal_o(illegal_o), .mtvec_o(mtvec_o),
        .mepc_o(mepc_o), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              v, fl, ret, tr, mr;
        logic [2:0]      op;
        logic [11:0]     addr;
        logic [4:0]      rs1, rd;
        logic [XLEN-1:0] d, tpc, tcause;
    } req_t;

    typedef struct {
        bit              ill;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              due;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] m_csr [int];
    int              total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: CSRs by architectural address, aliases folded on read.
    function automatic int canon(input logic [11:0] a);
        if (a == 12'hC00) return 'hB00;
        if (a == 12'hC02) return 'hB02;
        return int'(a);
    endfunction

    function automatic bit m_mapped(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB02, 12'hC00, 12'hC02};
    endfunction

    function automatic logic [XLEN-1:0] m_store_val(input logic [11:0] a, input logic [XLEN-1:0] v);
        if (a == 12'h300) return v & XLEN'('h88);
        if (a == 12'h305 || a == 12'h341) return v & ~XLEN'(3);
        return v;
    endfunction

    task automatic m_reset();
        foreach (m_csr[k]) m_csr[k] = '0;
        exp_q.delete();
    endtask

    function automatic req_t mk(input logic [2:0] op, input logic [11:0] addr,
                                input logic [4:0] rs1, input logic [XLEN-1:0] d,
                                input logic [4:0] rd);
        req_t r;
        r = '{default: '0};
        r.v = 1'b1; r.op = op; r.addr = addr; r.rs1 = rs1; r.d = d; r.rd = rd;
        return r;
    endfunction

    function automatic req_t idle();
        req_t r;
        r = '{default: '0};
        return r;
    endfunction

    task automatic step(input req_t r);
        logic [XLEN-1:0] old_v, src, nv;
        bit              accept, ill, wr;
        logic [XLEN-1:0] next_cyc, next_ins, ms;
        exp_t            e;
        valid_i = r.v; flush_i = r.fl; csr_op_i = r.op; csr_addr_i = r.addr;
        rs1_idx_i = r.rs1; data_rs1_i = r.d; rd_idx_i = r.rd; retire_i = r.ret;
        trap_i = r.tr; trap_pc_i = r.tpc; trap_cause_i = r.tcause; mret_i = r.mr;

        accept = r.v && !r.fl && !r.tr && !r.mr;
        old_v  = m_mapped(r.addr) ? m_csr[canon(r.addr)] : '0;
        src    = r.op[2] ? XLEN'(r.rs1) : r.d;
        wr     = (r.op == 3'b001 || r.op == 3'b101) || r.rs1 != 0;
        ill    = !(r.op inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111})
                 || !m_mapped(r.addr) || (wr && r.addr[11:10] == 2'b11);
        case (r.op[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old_v | src;
            default: nv = old_v & ~src;
        endcase
        if (accept && (ill || r.rd != 0)) begin
            e.ill = ill; e.rd = r.rd; e.data = old_v; e.due = cyc + 1;
            exp_q.push_back(e);
        end
        next_cyc = m_csr['hB00] + 1;
        next_ins = m_csr['hB02] + (r.ret ? 1 : 0);

        @(posedge clk);
        m_csr['hB00] = next_cyc;
        m_csr['hB02] = next_ins;
        ms = m_csr['h300];
        if (r.tr) begin
            m_csr['h341] = r.tpc & ~XLEN'(3);
            m_csr['h342] = r.tcause;
            m_csr['h300] = ms[3] ? XLEN'('h80) : '0;
        end else if (r.mr) begin
            m_csr['h300] = XLEN'('h80) | (ms[7] ? XLEN'('h08) : '0);
        end else if (accept && !ill && wr) begin
            m_csr[canon(r.addr)] = m_store_val(r.addr, nv);
        end
        #1;
        check("mtvec_o", mtvec_o, m_csr['h305]);
        check("mepc_o", mepc_o, m_csr['h341]);
        check("mie_o", XLEN'(mie_o), XLEN'(m_csr['h300][3]));
    endtask

    // Monitor: any writeback or illegal pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid_o || illegal_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", XLEN'({illegal_o, wb_valid_o}), '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_cycle", XLEN'(cyc), XLEN'(e.due));
                    check("out_kind", XLEN'({illegal_o, wb_valid_o}), e.ill ? XLEN'(2) : XLEN'(1));
                    if (!e.ill) begin
                        check("wb_rd_idx", XLEN'(wb_rd_idx_o), XLEN'(e.rd));
                        check("wb_data", wb_data_o, e.data);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("missing_output", XLEN'({illegal_o, wb_valid_o}), e.ill ? XLEN'(2) : XLEN'(1));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] addrs [10];
        req_t        r;
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'h7C0};
        foreach (addrs[k]) if (addrs[k][11:8] != 4'hC && addrs[k] != 12'h7C0) m_csr[int'(addrs[k])] = '0;

        do_reset();
        check("reset_wb_valid", XLEN'(wb_valid_o), '0);
        check("reset_wb_rd", XLEN'(wb_rd_idx_o), '0);
        check("reset_wb_data", wb_data_o, '0);
        check("reset_illegal", XLEN'(illegal_o), '0);
        check("reset_mtvec", mtvec_o, '0);
        check("reset_mie", XLEN'(mie_o), '0);

        // rw/rs on mscratch, back-to-back
        step(mk(3'b001, 12'h340, 5'd1, 64'h1234, 5'd5));
        step(mk(3'b010, 12'h340, 5'd0, 64'hFFFF, 5'd6));
        step(mk(3'b010, 12'h340, 5'd0, 64'h0, 5'd6));
        // immediate forms and forced low bits
        step(mk(3'b101, 12'h305, 5'h1F, 64'h0, 5'd0));
        check("mtvec_forced_bits", mtvec_o, 64'h1C);
        step(mk(3'b110, 12'h300, 5'd8, 64'h0, 5'd1));
        check("mie_set", XLEN'(mie_o), 64'd1);
        step(mk(3'b111, 12'h300, 5'd8, 64'h0, 5'd1));
        check("mie_cleared", XLEN'(mie_o), 64'd0);
        // illegal accesses
        step(mk(3'b001, 12'hC00, 5'd3, 64'h55, 5'd4));
        step(mk(3'b001, 12'h7C0, 5'd3, 64'h55, 5'd4));
        step(mk(3'b100, 12'h340, 5'd3, 64'h55, 5'd4));
        step(mk(3'b010, 12'hC02, 5'd2, 64'h1, 5'd4));
        step(mk(3'b010, 12'hC00, 5'd0, 64'h0, 5'd7));
        step(mk(3'b010, 12'h340, 5'd0, 64'h0, 5'd6));
        // trap with concurrent request, then mret, then both together
        step(mk(3'b110, 12'h300, 5'd8, 64'h0, 5'd0));
        r = mk(3'b001, 12'h340, 5'd1, 64'hDEAD, 5'd8);
        r.tr = 1'b1; r.tpc = 64'h80000102; r.tcause = 64'hB;
        step(r);
        check("trap_mepc", mepc_o, 64'h80000100);
        check("trap_mie", XLEN'(mie_o), 64'd0);
        step(mk(3'b010, 12'h342, 5'd0, 64'h0, 5'd9));
        step(mk(3'b010, 12'h300, 5'd0, 64'h0, 5'd9));
        r = mk(3'b001, 12'h340, 5'd1, 64'hBEEF, 5'd8);
        r.mr = 1'b1;
        step(r);
        check("mret_mie", XLEN'(mie_o), 64'd1);
        r = idle(); r.tr = 1'b1; r.mr = 1'b1; r.tpc = 64'h40; r.tcause = 64'h3;
        step(r);
        step(mk(3'b010, 12'h340, 5'd0, 64'h0, 5'd9));
        // mcycle wrap and write-wins, minstret counting
        step(mk(3'b001, 12'hB00, 5'd1, '1, 5'd0));
        step(mk(3'b010, 12'hB00, 5'd0, 64'h0, 5'd10));
        step(mk(3'b010, 12'hB00, 5'd0, 64'h0, 5'd10));
        step(mk(3'b010, 12'hC00, 5'd0, 64'h0, 5'd10));
        for (int i = 0; i < 12; i++) begin
            r = idle(); r.ret = (i % 3 != 0);
            step(r);
        end
        r = mk(3'b010, 12'hC02, 5'd0, 64'h0, 5'd11); r.ret = 1'b1;
        step(r);
        step(mk(3'b010, 12'hB02, 5'd0, 64'h0, 5'd11));
        // flushed request
        r = mk(3'b001, 12'h340, 5'd1, 64'h77, 5'd12); r.fl = 1'b1;
        step(r);
        step(mk(3'b010, 12'h340, 5'd0, 64'h0, 5'd12));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r.v      = ($urandom_range(0, 3) != 0);
            r.fl     = ($urandom_range(0, 9) == 0);
            r.op     = 3'($urandom_range(0, 7));
            r.addr   = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)];
            r.rs1    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            r.d      = {$urandom, $urandom};
            r.rd     = 5'($urandom);
            r.ret    = 1'($urandom);
            r.tr     = ($urandom_range(0, 15) == 0);
            r.mr     = ($urandom_range(0, 15) == 0);
            r.tpc    = {$urandom, $urandom};
            r.tcause = {$urandom, $urandom};
            step(r);
        end

        // reset asserted while a writeback is being presented
        step(mk(3'b001, 12'h340, 5'd1, 64'hABCD, 5'd9));
        rst_n = 1'b0;
        #1;
        check("async_reset_wb_valid", XLEN'(wb_valid_o), '0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(3'b010, 12'h340, 5'd0, 64'h0, 5'd9));
        step(mk(3'b010, 12'h305, 5'd0, 64'h0, 5'd9));
        step(mk(3'b010, 12'hB02, 5'd0, 64'h0, 5'd9));
        repeat (3) step(idle());
        check("scoreboard_drained", XLEN'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
